// File: rtl/sal_cmd_pkg.sv
// Shared types and helpers for the channel command arbiter.
// Command encodings, class indices and the timing-counter width helper.
package sal_cmd_pkg;

  typedef enum logic [2:0] {
    NOP = 3'd0,
    ACT = 3'd1,
    RD  = 3'd2,
    WR  = 3'd3,
    PRE = 3'd4,
    REF = 3'd5
  } cmd_type_t;

  // Class index order doubles as priority order: lower index wins.
  localparam int CLS_REF   = 0;
  localparam int CLS_COL   = 1;
  localparam int CLS_ACT   = 2;
  localparam int CLS_PRE   = 3;
  localparam int NUM_CLS   = 4;

  localparam int FAW_SLOTS = 4;

  function automatic int cnt_w(input int t);
    return (t < 2) ? 1 : $clog2(t);
  endfunction

endpackage

// File: rtl/sal_rr_arb.sv
// Round-robin one-hot arbiter: search starts at the pointer and wraps.
// The pointer moves past the winner only when the caller commits the grant.
module sal_rr_arb #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  input  logic         en_i,
  output logic [N-1:0] gnt_o
);

  localparam int PW = (N < 2) ? 1 : $clog2(N);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] idx;
  logic [PW-1:0] win;
  logic          found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    win   = ptr_q;
    idx   = ptr_q;
    for (int k = 0; k < N; k++) begin
      idx = ptr_q + PW'(k);
      if (!found && req_i[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    if (found) gnt_o[win] = 1'b1;
  end

  assign ptr_d = win + PW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (en_i && found) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/sal_cmd_arb.sv
// Channel command arbiter: one grant per cycle by class priority with inter-bank timing.
// Define SAL_TFAW_EN to add the four-activate-window limit on ACT.
module sal_cmd_arb
  import sal_cmd_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int BA_WIDTH  = 2,
  parameter int RA_WIDTH  = 16,
  parameter int CA_WIDTH  = 10,
  parameter int ID_WIDTH  = 4,
  parameter int LEN_WIDTH = 4,
  parameter int T_RRD     = 4,
  parameter int T_CCD     = 4,
  parameter int T_WTR     = 6,
  parameter int T_RTW     = 8,
  parameter int T_FAW     = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_BANKS-1:0]           act_req_i,
  input  logic [NUM_BANKS-1:0]           rd_req_i,
  input  logic [NUM_BANKS-1:0]           wr_req_i,
  input  logic [NUM_BANKS-1:0]           pre_req_i,
  input  logic [NUM_BANKS-1:0]           ref_req_i,
  input  logic [NUM_BANKS*RA_WIDTH-1:0]  ra_i,
  input  logic [NUM_BANKS*CA_WIDTH-1:0]  ca_i,
  input  logic [NUM_BANKS*ID_WIDTH-1:0]  id_i,
  input  logic [NUM_BANKS*LEN_WIDTH-1:0] len_i,
  output logic [NUM_BANKS-1:0]           act_gnt_o,
  output logic [NUM_BANKS-1:0]           rd_gnt_o,
  output logic [NUM_BANKS-1:0]           wr_gnt_o,
  output logic [NUM_BANKS-1:0]           pre_gnt_o,
  output logic [NUM_BANKS-1:0]           ref_gnt_o,
  output logic                           cmd_valid_o,
  output logic [2:0]                     cmd_type_o,
  output logic [BA_WIDTH-1:0]            cmd_ba_o,
  output logic [RA_WIDTH-1:0]            cmd_ra_o,
  output logic [CA_WIDTH-1:0]            cmd_ca_o,
  output logic [ID_WIDTH-1:0]            cmd_id_o,
  output logic [LEN_WIDTH-1:0]           cmd_len_o
);

  localparam int RRD_W = cnt_w(T_RRD);
  localparam int CCD_W = cnt_w(T_CCD);
  localparam int WTR_W = cnt_w(T_WTR);
  localparam int RTW_W = cnt_w(T_RTW);

  genvar gi;

  if (NUM_BANKS != (1 << BA_WIDTH) || T_RRD < 1 || T_CCD < 1 || T_WTR < 1 ||
      T_RTW < 1 || T_FAW < 1) begin : g_bad_param
    $error("sal_cmd_arb: illegal parameter combination");
  end

  logic [RRD_W-1:0] rrd_q;
  logic [CCD_W-1:0] ccd_q;
  logic [WTR_W-1:0] wtr_q;
  logic [RTW_W-1:0] rtw_q;
  logic             col_wr_q;

  logic act_ok, rd_ok, wr_ok, faw_ok, sel_wr;
  logic [NUM_BANKS-1:0] rd_v, wr_v, act_v, gnt_vec;
  logic [NUM_BANKS-1:0] cls_req [NUM_CLS];
  logic [NUM_BANKS-1:0] cls_gnt [NUM_CLS];
  logic [NUM_CLS-1:0]   cls_any, cls_en;

  logic                 cmd_valid_q, cmd_valid_d;
  cmd_type_t            cmd_type_q, cmd_type_d;
  logic [BA_WIDTH-1:0]  cmd_ba_q, cmd_ba_d;
  logic [RA_WIDTH-1:0]  cmd_ra_q, cmd_ra_d;
  logic [CA_WIDTH-1:0]  cmd_ca_q, cmd_ca_d;
  logic [ID_WIDTH-1:0]  cmd_id_q, cmd_id_d;
  logic [LEN_WIDTH-1:0] cmd_len_q, cmd_len_d;

  assign rd_ok  = (ccd_q == '0) && (wtr_q == '0);
  assign wr_ok  = (ccd_q == '0) && (rtw_q == '0);
  assign act_ok = (rrd_q == '0) && faw_ok;

  assign rd_v  = rd_req_i  & {NUM_BANKS{rd_ok}};
  assign wr_v  = wr_req_i  & {NUM_BANKS{wr_ok}};
  assign act_v = act_req_i & {NUM_BANKS{act_ok}};

  // Stay on the last column direction while it has eligible work, to avoid turnarounds.
  assign sel_wr = (|wr_v) && (col_wr_q || !(|rd_v));

  assign cls_req[CLS_REF] = ref_req_i;
  assign cls_req[CLS_COL] = sel_wr ? wr_v : rd_v;
  assign cls_req[CLS_ACT] = act_v;
  assign cls_req[CLS_PRE] = pre_req_i;

  for (gi = 0; gi < NUM_CLS; gi++) begin : g_cls
    assign cls_any[gi] = |cls_req[gi];
    assign cls_en[gi]  = !rst && cls_any[gi] &&
                         !(|(cls_any & NUM_CLS'((1 << gi) - 1)));
    sal_rr_arb #(.N(NUM_BANKS)) u_rr (
      .clk   (clk),
      .rst   (rst),
      .req_i (cls_req[gi]),
      .en_i  (cls_en[gi]),
      .gnt_o (cls_gnt[gi])
    );
  end

  assign ref_gnt_o = cls_en[CLS_REF] ? cls_gnt[CLS_REF] : '0;
  assign rd_gnt_o  = (cls_en[CLS_COL] && !sel_wr) ? cls_gnt[CLS_COL] : '0;
  assign wr_gnt_o  = (cls_en[CLS_COL] &&  sel_wr) ? cls_gnt[CLS_COL] : '0;
  assign act_gnt_o = cls_en[CLS_ACT] ? cls_gnt[CLS_ACT] : '0;
  assign pre_gnt_o = cls_en[CLS_PRE] ? cls_gnt[CLS_PRE] : '0;
  assign gnt_vec   = ref_gnt_o | rd_gnt_o | wr_gnt_o | act_gnt_o | pre_gnt_o;

  always_comb begin
    cmd_valid_d = |gnt_vec;
    cmd_type_d  = NOP;
    cmd_ba_d    = '0;
    cmd_ra_d    = '0;
    cmd_ca_d    = '0;
    cmd_id_d    = '0;
    cmd_len_d   = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (gnt_vec[b]) cmd_ba_d = BA_WIDTH'(b);
    end
    if (cls_en[CLS_REF])      cmd_type_d = REF;
    else if (cls_en[CLS_COL]) cmd_type_d = sel_wr ? WR : RD;
    else if (cls_en[CLS_ACT]) cmd_type_d = ACT;
    else if (cls_en[CLS_PRE]) cmd_type_d = PRE;
    if (cls_en[CLS_ACT]) cmd_ra_d = ra_i[cmd_ba_d*RA_WIDTH +: RA_WIDTH];
    if (cls_en[CLS_COL]) begin
      cmd_ca_d  = ca_i[cmd_ba_d*CA_WIDTH +: CA_WIDTH];
      cmd_id_d  = id_i[cmd_ba_d*ID_WIDTH +: ID_WIDTH];
      cmd_len_d = len_i[cmd_ba_d*LEN_WIDTH +: LEN_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rrd_q    <= '0;
      ccd_q    <= '0;
      wtr_q    <= '0;
      rtw_q    <= '0;
      col_wr_q <= 1'b0;
    end else begin
      rrd_q <= cls_en[CLS_ACT] ? RRD_W'(T_RRD - 1) :
               (rrd_q != '0) ? rrd_q - RRD_W'(1) : '0;
      ccd_q <= cls_en[CLS_COL] ? CCD_W'(T_CCD - 1) :
               (ccd_q != '0) ? ccd_q - CCD_W'(1) : '0;
      wtr_q <= (cls_en[CLS_COL] && sel_wr) ? WTR_W'(T_WTR - 1) :
               (wtr_q != '0) ? wtr_q - WTR_W'(1) : '0;
      rtw_q <= (cls_en[CLS_COL] && !sel_wr) ? RTW_W'(T_RTW - 1) :
               (rtw_q != '0) ? rtw_q - RTW_W'(1) : '0;
      if (cls_en[CLS_COL]) col_wr_q <= sel_wr;
    end
  end

`ifdef SAL_TFAW_EN
  localparam int FAW_W = cnt_w(T_FAW);

  logic [FAW_SLOTS-1:0][FAW_W-1:0] faw_q;
  logic [FAW_SLOTS-1:0]            faw_free;
  logic [FAW_SLOTS-1:0]            faw_load;
  logic                            faw_hit;

  for (gi = 0; gi < FAW_SLOTS; gi++) begin : g_faw_free
    assign faw_free[gi] = (faw_q[gi] == '0);
  end

  // An expired slot is the oldest one; only one is claimed per ACT.
  always_comb begin
    faw_load = '0;
    faw_hit  = 1'b0;
    for (int s = 0; s < FAW_SLOTS; s++) begin
      if (faw_free[s] && !faw_hit) begin
        faw_load[s] = 1'b1;
        faw_hit     = 1'b1;
      end
    end
  end

  assign faw_ok = |faw_free;

  always_ff @(posedge clk) begin
    if (rst) begin
      faw_q <= '0;
    end else begin
      for (int s = 0; s < FAW_SLOTS; s++) begin
        if (cls_en[CLS_ACT] && faw_load[s]) faw_q[s] <= FAW_W'(T_FAW - 1);
        else if (!faw_free[s])              faw_q[s] <= faw_q[s] - FAW_W'(1);
      end
    end
  end
`else
  assign faw_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_valid_q <= 1'b0;
      cmd_type_q  <= NOP;
      cmd_ba_q    <= '0;
      cmd_ra_q    <= '0;
      cmd_ca_q    <= '0;
      cmd_id_q    <= '0;
      cmd_len_q   <= '0;
    end else begin
      cmd_valid_q <= cmd_valid_d;
      cmd_type_q  <= cmd_type_d;
      cmd_ba_q    <= cmd_ba_d;
      cmd_ra_q    <= cmd_ra_d;
      cmd_ca_q    <= cmd_ca_d;
      cmd_id_q    <= cmd_id_d;
      cmd_len_q   <= cmd_len_d;
    end
  end

  assign cmd_valid_o = cmd_valid_q;
  assign cmd_type_o  = cmd_type_q;
  assign cmd_ba_o    = cmd_ba_q;
  assign cmd_ra_o    = cmd_ra_q;
  assign cmd_ca_o    = cmd_ca_q;
  assign cmd_id_o    = cmd_id_q;
  assign cmd_len_o   = cmd_len_q;

endmodule

// File: doc/sal_cmd_arb.md
Name: sal_cmd_arb

Overview:
Channel-level command arbiter between NUM_BANKS per-bank controllers and the DRAM command bus.
- Each bank controller raises ACT/RD/WR/PRE/REF requests. The arbiter grants at most one per cycle.
- Grant is chosen by class priority, with round-robin order inside each class.
- Inter-bank timing (tRRD, tCCD, tWTR, tRTW) is enforced here. Per-bank timing stays in the bank controllers.
- The granted command is registered and driven to the PHY/command encoder one cycle later.

Parameters:
NUM_BANKS, 4, number of bank controllers (power of 2, 2..16)
BA_WIDTH, 2, log2(NUM_BANKS)
RA_WIDTH, 16, row address width
CA_WIDTH, 10, column address width
ID_WIDTH, 4, request ID width
LEN_WIDTH, 4, burst length field width
T_RRD, 4, min cycles ACT->ACT (any banks), >=1
T_CCD, 4, min cycles column->column, >=1
T_WTR, 6, min cycles WR->RD, >=1
T_RTW, 8, min cycles RD->WR, >=1
T_FAW, 16, four-activate window in cycles (used only with SAL_TFAW_EN)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
act_req_i  in  NUM_BANKS  per-bank ACTIVATE request
rd_req_i  in  NUM_BANKS  per-bank READ request
wr_req_i  in  NUM_BANKS  per-bank WRITE request
pre_req_i  in  NUM_BANKS  per-bank PRECHARGE request
ref_req_i  in  NUM_BANKS  per-bank REFRESH request
ra_i  in  NUM_BANKS*RA_WIDTH  per-bank row address; bank b at [b*RA_WIDTH +: RA_WIDTH]
ca_i  in  NUM_BANKS*CA_WIDTH  per-bank column address
id_i  in  NUM_BANKS*ID_WIDTH  per-bank request ID
len_i  in  NUM_BANKS*LEN_WIDTH  per-bank burst length
act_gnt_o, rd_gnt_o, wr_gnt_o, pre_gnt_o, ref_gnt_o  out  NUM_BANKS each  combinational one-hot grants
cmd_valid_o  out  1  registered command valid
cmd_type_o  out  3  cmd_type_t encoding
cmd_ba_o  out  BA_WIDTH  bank of issued command
cmd_ra_o  out  RA_WIDTH  row address (ACT only, else 0)
cmd_ca_o  out  CA_WIDTH  column address (RD/WR only, else 0)
cmd_id_o  out  ID_WIDTH  ID (RD/WR only, else 0)
cmd_len_o  out  LEN_WIDTH  burst length (RD/WR only, else 0)

Behaviour:
- Grant timing and handshake:
  - Grants are combinational and asserted in the same cycle as the request. Bank controllers sample them in that cycle.
  - At most one bit across all five grant vectors is set per cycle.
  - A grant is never given to a deasserted request.
  - A request is not latched. If it drops before being granted, it is lost with no side effect.
- Class priority, highest first: REF > RD/WR > ACT > PRE.
  - RD and WR form one column class. Within that class, a request of the same type as the last column command wins first (minimizes turnaround). After reset, RD wins.
- Round-robin inside each class:
  - Five pointers (REF, COL, ACT, PRE, plus a shared column-type bit).
  - On grant to bank b, the class pointer becomes (b+1) mod NUM_BANKS. The pointer holds when there is no grant in that class.
  - Search starts at the pointer and wraps.
- Eligibility:
  - ACT needs rrd_cnt==0.
  - RD needs ccd_cnt==0 and wtr_cnt==0.
  - WR needs ccd_cnt==0 and rtw_cnt==0.
  - PRE and REF are always eligible.
  - An ineligible class is skipped and the next class may win in the same cycle.
- Timing counters:
  - Each counter loads T_x-1 on a grant of its triggering command. Otherwise it decrements, saturating at 0.
  - With T_x=1, commands may issue back-to-back.
  - ACT grant loads rrd_cnt.
  - RD or WR grant loads ccd_cnt.
  - WR grant loads wtr_cnt.
  - RD grant loads rtw_cnt.
- Output register:
  - On any grant, the cmd_* registers load the granted command in the next cycle and cmd_valid_o=1.
  - With no grant, cmd_valid_o=0 and the other cmd_* outputs are 0.
  - Latency from request to cmd_valid_o is 1 cycle.
- Reset values while rst=1:
  - All grants forced to 0.
  - cmd_valid_o=0 and all cmd_* outputs are 0.
  - All counters 0, all pointers 0, column-type bit = RD.
  - Reset mid-burst discards all timing history. The first command after reset is unconstrained.
- Simultaneous events: a request in a higher class always beats a lower one, even if the lower request has waited longer. Starvation of PRE is accepted because bank controllers drop a hit only after it is serviced.

Optional Feature:
SAL_TFAW_EN
- Defined: a 4-entry window of ACT age counters, each T_FAW wide.
  - On each ACT grant, the oldest slot is loaded with T_FAW-1. All slots decrement, saturating at 0.
  - ACT is additionally eligible only when at least one slot is 0.
- Undefined: no tFAW logic, and T_FAW is ignored.

Decomposition:
- Package sal_cmd_pkg:
  - cmd_type_t enum: NOP=0, ACT=1, RD=2, WR=3, PRE=4, REF=5.
  - Counter width localparams derived with $clog2.
- Sub-module sal_rr_arb (params N):
  - Inputs req[N], en; output gnt[N] one-hot.
  - Internal pointer register, advanced on en&|gnt.
  - Instantiated for the REF, COL, ACT and PRE classes.

Test Plan:
- Reset: hold rst=1 with all req_i=1 -> all gnt=0 and cmd_valid_o=0. First cycle after release -> ref_gnt_o=0001; next cycle cmd_type_o=REF, cmd_ba_o=0.
- Round-robin: act_req_i=1111 held, T_RRD=1 -> act_gnt_o=0001,0010,0100,1000,0001 on consecutive cycles.
- tRRD: act_req_i=0011, T_RRD=4 -> ACT bank0 at cycle t, ACT bank1 at t+4, no ACT at t+1..t+3.
- Turnaround: WR bank0 granted at t, rd_req_i=0010 from t+1, T_WTR=6, T_CCD=4 -> rd_gnt_o=0010 first at t+6.
- Priority: at the same cycle ref_req_i=0100, rd_req_i=0001, pre_req_i=1000 with counters 0 -> ref_gnt_o=0100 only. Next cycle -> rd_gnt_o=0001.
- SAL_TFAW_EN with T_FAW=16, T_RRD=1, act_req_i=1111 -> ACTs at t..t+3, fifth ACT at t+16.
